// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame capture and launch/wait/hold sequencer in front of a sequential FFT core.
// Optional watchdog abort of a stuck core: define FFT_TIMEOUT_EN.
module fft_frame_scheduler #(
  parameter int SAMPLES = 16,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            fft_rst,
  output logic [SAMPLES-1:0][WIDTH-1:0]   fft_samples,
  input  logic                            fft_out_valid,
  input  logic [SAMPLES-1:0][WIDTH-1:0]   fft_outputs,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [SAMPLES-1:0][WIDTH-1:0]   res_data,
  output logic                            busy,
  output logic [15:0]                     frame_cnt,
  output logic                            err_timeout,
  output logic [1:0]                      state_dbg
);

  localparam int IDX_W = $clog2(SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                          state, state_nxt;
  logic                            wr_bank, rd_bank;
  logic [IDX_W-1:0]                wr_idx;
  logic [1:0]                      full;
  logic [SAMPLES-1:0][WIDTH-1:0]   bank [2];

  logic wr_en, wr_last, cap, wd_expire, rd_free, res_take;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // valid never depends on ready, and the payload is only meaningful while valid is 1.
  assign in_ready = !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign wr_last  = wr_en && (wr_idx == IDX_W'(SAMPLES - 1));
  assign cap      = (state == S_WAIT) && fft_out_valid;
  assign rd_free  = cap || wd_expire;
  assign res_take = (state == S_HOLD) && res_ready;

  assign fft_samples = bank[rd_bank];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (full[rd_bank]) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (fft_out_valid)  state_nxt = S_HOLD;
        else if (wd_expire) state_nxt = S_IDLE;
      end
      S_HOLD:   if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fft_rst   = rst || (state == S_LAUNCH);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  // ---------------- capture side ----------------
  always_ff @(posedge clk) begin
    if (wr_en) bank[wr_bank][wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end
  end

  // Free and fill always hit different banks: a freed bank is the read bank, which is full,
  // so the write side cannot be completing into it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
    end else begin
      if (rd_free) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (wr_last) full[wr_bank] <= 1'b1;
    end
  end

  // ---------------- result side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      frame_cnt <= 16'd0;
    end else begin
      if (cap) begin
        res_valid <= 1'b1;
        res_data  <= fft_outputs;
      end else if (res_take) begin
        res_valid <= 1'b0;
      end
      if (res_take) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // ---------------- watchdog ----------------
`ifdef FFT_TIMEOUT_EN
  logic [15:0] wdog;

  // Expires on the TIMEOUT-th WAIT cycle unless the core answers in that same cycle.
  assign wd_expire = (state == S_WAIT) && !fft_out_valid && (wdog == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_LAUNCH)    wdog <= 16'd0;
      else if (state == S_WAIT) wdog <= wdog + 16'd1;
      if (wd_expire) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: source, FFT core model and sink are all
// advanced from one negedge-aligned step task driven by a single linear initial block.
module tb_fft_frame_scheduler;

  localparam int SAMPLES = 16;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam logic [WIDTH-1:0] MASK = 32'h5A5A_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                          in_valid, in_ready;
  logic [WIDTH-1:0]              in_data;
  logic                          fft_rst;
  logic [SAMPLES-1:0][WIDTH-1:0] fft_samples;
  logic                          fft_out_valid;
  logic [SAMPLES-1:0][WIDTH-1:0] fft_outputs;
  logic                          res_valid, res_ready;
  logic [SAMPLES-1:0][WIDTH-1:0] res_data;
  logic                          busy;
  logic [15:0]                   frame_cnt;
  logic                          err_timeout;
  logic [1:0]                    state_dbg;

  fft_frame_scheduler #(.SAMPLES(SAMPLES), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fft_rst(fft_rst), .fft_samples(fft_samples),
    .fft_out_valid(fft_out_valid), .fft_outputs(fft_outputs),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .frame_cnt(frame_cnt), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // ---------------- environment state ----------------
  int  n_chk, n_pass, n_fail;
  int  lat_cnt, fft_lat;
  bit  stale, stale_clr, pulse;
  logic [SAMPLES-1:0][WIDTH-1:0] snap;
  bit  src_en, sink_rdy;
  logic [WIDTH-1:0] next_val;
  int  acc_cnt, ready_drop, got_frames, resv_cycles;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [SAMPLES*WIDTH-1:0] obs,
                             input logic [SAMPLES*WIDTH-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a negedge: drives inputs for the coming posedge, then waits for the next negedge.
  task automatic step();
    logic [SAMPLES-1:0][WIDTH-1:0] expf;
    logic [WIDTH-1:0] s [SAMPLES];
    // core model: answer fft_lat cycles after the launch strobe, result = reversed ^ MASK
    if (stale_clr) begin
      stale     = 1'b0;
      stale_clr = 1'b0;
    end
    pulse = 1'b0;
    if (rst) lat_cnt = 0;
    else if (fft_rst) begin
      snap    = fft_samples;
      lat_cnt = fft_lat;
      if (stale) stale_clr = 1'b1;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) pulse = 1'b1;
    end
    fft_out_valid = stale | pulse;
    for (int i = 0; i < SAMPLES; i++)
      fft_outputs[i] = pulse ? (snap[SAMPLES-1-i] ^ MASK) : 32'hDEAD_BEEF;
    // source
    in_valid = src_en;
    in_data  = next_val;
    if (src_en && !in_ready) ready_drop++;
    if (in_valid && in_ready && !rst) begin
      exp_q.push_back(in_data);
      next_val = next_val + 32'd100;
      acc_cnt++;
    end
    // sink
    res_ready = sink_rdy;
    if (res_valid) resv_cycles++;
    if (res_valid && res_ready && !rst) begin
      if (exp_q.size() >= SAMPLES) begin
        for (int i = 0; i < SAMPLES; i++) s[i] = exp_q.pop_front();
        for (int i = 0; i < SAMPLES; i++) expf[i] = s[SAMPLES-1-i] ^ MASK;
        check_frame("res_data", res_data, expf);
      end else begin
        check("res_without_frame", 32'(exp_q.size()), 32'(SAMPLES));
      end
      got_frames++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    src_en = 1'b0;
    repeat (n) step();
    rst        = 1'b0;
    exp_q.delete();
    acc_cnt    = 0;
    got_frames = 0;
    ready_drop = 0;
  endtask

  task automatic feed_until(input int target, input int bound);
    int g;
    g = 0;
    src_en = 1'b1;
    while (acc_cnt < target && g < bound) begin
      step();
      g++;
    end
    src_en = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic wait_frames(input int target, input int bound);
    int g;
    g = 0;
    while (32'(frame_cnt) < target && g < bound) begin
      step();
      g++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, resv0, waitc;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    fft_out_valid = 1'b0; fft_outputs = '0;
    lat_cnt = 0; fft_lat = 8; stale = 1'b0; stale_clr = 1'b0; pulse = 1'b0; snap = '0;
    src_en = 1'b0; sink_rdy = 1'b1; next_val = '0;
    acc_cnt = 0; ready_drop = 0; got_frames = 0; resv_cycles = 0;
    @(negedge clk);

    // 1. reset state and basic frame
    step(); step();
    check("rst_fft_rst", 32'(fft_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_res_data0", res_data[0], 32'd0);
    do_reset(0);
    next_val = 32'd0;
    feed_until(16, 40);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_fft_rst", 32'(fft_rst), 32'd0);
    step();
    check("t1_launch_fft_rst", 32'(fft_rst), 32'd1);
    check("t1_launch_state", 32'(state_dbg), 32'd1);
    check("t1_samples15", fft_samples[15], 32'd1500);
    check("t1_samples0", fft_samples[0], 32'd0);
    step();
    check("t1_fft_rst_1cycle", 32'(fft_rst), 32'd0);
    check("t1_wait_state", 32'(state_dbg), 32'd2);
    wait_res(n);
    check("t1_res_latency", 32'(n), 32'd8);
    resv0 = resv_cycles;
    step();
    check("t1_res_valid_fall", 32'(res_valid), 32'd0);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_got_frames", 32'(got_frames), 32'd1);
    step();
    check("t1_res_valid_1cycle", 32'(resv_cycles - resv0), 32'd1);

    // 2. ping-pong: 48 back-to-back samples
    do_reset(1);
    sink_rdy = 1'b1;
    next_val = 32'd20000;
    feed_until(48, 100);
    wait_frames(3, 60);
    check("t2_ready_drops", 32'(ready_drop), 32'd0);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd3);
    check("t2_got_frames", 32'(got_frames), 32'd3);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3. back-pressure: consumer stalls for 100 cycles under continuous input
    do_reset(1);
    sink_rdy = 1'b0;
    next_val = 32'd40000;
    src_en   = 1'b1;
    repeat (100) step();
    check("t3_accepted", 32'(acc_cnt), 32'd48);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_hold", 32'(state_dbg), 32'd3);
    check("t3_res_valid", 32'(res_valid), 32'd1);
    check("t3_frame_cnt0", 32'(frame_cnt), 32'd0);
    sink_rdy = 1'b1;
    feed_until(96, 200);
    wait_frames(6, 100);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd6);
    check("t3_got_frames", 32'(got_frames), 32'd6);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4. reset while 7 samples are buffered and the core is running
    do_reset(1);
    next_val = 32'd60000;
    feed_until(23, 60);
    check("t4_in_wait", 32'(state_dbg), 32'd2);
    check("t4_no_result_yet", 32'(res_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_res_valid", 32'(res_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete(); acc_cnt = 0; got_frames = 0;
    next_val = 32'd7000;
    feed_until(16, 40);
    wait_frames(1, 40);
    check("t4_clean_frames", 32'(got_frames), 32'd1);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd1);

    // 6. stale out_valid held high into LAUNCH must be ignored
    stale = 1'b1;
    acc_cnt = 0;
    next_val = 32'd9000;
    feed_until(16, 40);
    check("t6_idle_no_res", 32'(res_valid), 32'd0);
    step();
    check("t6_launch", 32'(state_dbg), 32'd1);
    step();
    check("t6_wait_no_res", 32'(res_valid), 32'd0);
    check("t6_wait_state", 32'(state_dbg), 32'd2);
    wait_res(n);
    check("t6_res_latency", 32'(n), 32'd8);
    step();
    check("t6_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t6_got_frames", 32'(got_frames), 32'd2);

    // 5. core never answers
    do_reset(1);
    fft_lat  = 0;
    next_val = 32'd11000;
    feed_until(16, 40);
`ifdef FFT_TIMEOUT_EN
    waitc = 0;
    for (int k = 0; k < 200; k++) begin
      if (err_timeout) break;
      if (state_dbg == 2'd2) waitc++;
      step();
    end
    check("t5_wait_cycles", 32'(waitc), 32'(TIMEOUT));
    check("t5_err", 32'(err_timeout), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_no_res", 32'(res_valid), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (5) step();
    check("t5_err_sticky", 32'(err_timeout), 32'd1);
    check("t5_stays_idle", 32'(busy), 32'd0);
`else
    waitc = 0;
    repeat (200) step();
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_still_wait", 32'(state_dbg), 32'd2);
    check("t5_err", 32'(err_timeout), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_wait_unused", 32'(waitc), 32'd0);
`endif
    do_reset(1);
    check("end_err_cleared", 32'(err_timeout), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
